motor_ramp_ctrl: RTL
====================

Name: motor_ramp_ctrl

Overview:
Sequences one PWM_gen channel driving a DC motor through an H-bridge. Accepts target duty/direction commands over a valid/ready handshake and slews the applied duty toward the target at a fixed rate (soft start/stop). On a direction reversal it ramps to zero, holds a dead time, then flips direction, so the bridge is never reversed under load. Sits between the car's motion-control logic and the PWM_gen freq/duty inputs.

Parameters:
PWM_FREQ, 25_000, constant PWM frequency (Hz) presented on freq; must be nonzero.
TICK_DIV, 100_000, clk cycles per ramp tick (1 ms at 100 MHz); minimum 2.
STEP, 8, duty LSBs changed per tick; range 1..1023.
DEAD_TICKS, 10, ramp ticks spent at duty 0 before a direction flip; minimum 1.

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  command can be accepted this cycle
cmd_dir  in  1  requested direction (0 forward, 1 reverse)
cmd_duty  in  10  requested duty, /1024 scale
estop  in  1  emergency stop, level-sensitive, highest priority
freq  out  32  to PWM_gen freq
duty  out  10  applied duty, to PWM_gen duty
dir  out  1  applied direction, to H-bridge
busy  out  1  high in RAMP, BRAKE, DEAD
state  out  3  current FSM state (debug/LED)

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, duty 0, dir 0, target 0, freq PWM_FREQ, cmd_ready 1, busy 0, tick counter 0. Reset mid-ramp takes effect at that edge.
- Tick: free-running counter 0..TICK_DIV-1; tick is a 1-cycle pulse when count==TICK_DIV-1. Only reset clears it. duty changes only on tick (or estop).
- freq is constant PWM_FREQ at all times, never 0.
- Accept = cmd_valid && cmd_ready. cmd_ready = 1 in IDLE, RAMP, HOLD when estop==0; 0 in BRAKE, DEAD, or when estop==1.
- On accept with cmd_dir==dir: target <= cmd_duty; go RAMP if cmd_duty!=duty, else stay/return HOLD (IDLE if 0).
- On accept with cmd_dir!=dir: pend_dir <= cmd_dir, pend_duty <= cmd_duty, target <= 0; go BRAKE.
- States (encoding in package): IDLE=0, RAMP=1, HOLD=2, BRAKE=3, DEAD=4.
- IDLE: duty 0.
- RAMP: on tick, up: duty <= min(duty+STEP, target) computed at 11 bits (no wrap past 1023); down: duty <= (duty >= target+STEP) ? duty-STEP : target (11-bit compare). When the new duty equals target: HOLD if target!=0, else IDLE.
- Accept and tick in same cycle: the tick step uses the pre-accept target; the new target applies from the next tick.
- HOLD: duty stable; leaves only on accept or estop.
- BRAKE: ramps down as RAMP with target 0; when duty reaches 0 (or is already 0 on entry) go DEAD with dead counter 0.
- DEAD: duty 0; count ticks; after DEAD_TICKS ticks: dir <= pend_dir, target <= pend_duty, go RAMP (IDLE if pend_duty==0). dir only changes here.
- estop==1 (checked each cycle, over everything but reset): next edge duty 0, target 0, state IDLE, pending command dropped, dir unchanged. After release, normal IDLE operation.
- busy = state in {RAMP, BRAKE, DEAD}.

Decomposition:
- Package motor_pkg: state enum/localparams (IDLE..DEAD), DUTY_W=10, DUTY_MAX=1023.
- One sub-module natural: tick_gen (parameter DIV, outputs 1-cycle tick); the rest is one FSM + datapath.

Test Plan:
- Bench params TICK_DIV=4, STEP=8, DEAD_TICKS=2, PWM_FREQ=25000.
- Reset held 2 cycles -> duty 0, dir 0, freq 25000, cmd_ready 1, state 0, busy 0.
- Cmd (dir0, 40) -> duty 8,16,24,32,40 on 5 successive ticks (4 cycles apart), then state HOLD, busy 0.
- In HOLD at 100, cmd (dir0, 95) -> duty 95 at next tick (clamp, not 92); cmd 1023 from 1016 -> 1023, no wrap to 0.
- In HOLD at 24 dir0, cmd (dir1, 16) -> cmd_ready 0; duty 16,8,0; 2 ticks DEAD with dir 0; dir flips to 1; duty 8,16; HOLD; cmd_ready 1.
- Mid-ramp at duty 24, estop pulse -> duty 0 next edge, state IDLE, cmd_ready 0 during estop; cmd_valid during estop ignored; after release cmd (dir0, 8) -> duty 8 on next tick.
- Mid-BRAKE, reset low for 1 cycle -> all outputs at reset values next edge; pending reversal discarded (dir stays 0).

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the motor ramp controller: FSM state encoding
// and duty-cycle width shared by the controller and its testbench.
package motor_pkg;

    localparam int DUTY_W   = 10;
    localparam int DUTY_MAX = 1023;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_BRAKE = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_RAMP) || (s == ST_BRAKE) || (s == ST_DEAD);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks; the tick is
// high while the counter sits at DIV-1, so the consumer acts on that edge.
module tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int               CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Soft-start/stop sequencer for one PWM channel: slews duty toward the commanded
// target one STEP per tick and brakes to zero plus a dead time before reversing.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int PWM_FREQ   = 25_000,
    parameter int TICK_DIV   = 100_000,
    parameter int STEP       = 8,
    parameter int DEAD_TICKS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              estop,
    output logic [31:0]       freq,
    output logic [DUTY_W-1:0] duty,
    output logic              dir,
    output logic              busy,
    output logic [2:0]        state
);

    localparam logic [DUTY_W:0] STEP_X    = STEP[DUTY_W:0];
    localparam int              DEAD_W    = $clog2(DEAD_TICKS + 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DUTY_W-1:0]   r_duty;
    logic [DUTY_W-1:0]   w_duty_nxt;
    logic [DUTY_W-1:0]   r_target;
    logic [DUTY_W-1:0]   w_target_nxt;
    logic [DUTY_W-1:0]   r_pend_duty;
    logic [DUTY_W-1:0]   w_pend_duty_nxt;
    logic                r_dir;
    logic                w_dir_nxt;
    logic                r_pend_dir;
    logic                w_pend_dir_nxt;
    logic [DEAD_W-1:0]   r_dead_cnt;
    logic [DEAD_W-1:0]   w_dead_cnt_nxt;
    logic [DUTY_W-1:0]   w_ramp_duty;
    logic                w_tick;
    logic                w_accept;

    // One ramp step toward tgt; arithmetic is one bit wider so 1016+8 clamps
    // to the target instead of wrapping through zero.
    function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] c;
        logic [DUTY_W:0] t;
        logic [DUTY_W:0] sum;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (c < t) begin
            sum = c + STEP_X;
            ramp_step = (sum > t) ? tgt : sum[DUTY_W-1:0];
        end else if (c >= t + STEP_X) begin
            sum = c - STEP_X;
            ramp_step = sum[DUTY_W-1:0];
        end else begin
            ramp_step = tgt;
        end
    endfunction

    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .i_clk  (clk),
        .i_rst_n(reset),
        .o_tick (w_tick)
    );

    assign cmd_ready = !estop &&
                       ((r_state == ST_IDLE) || (r_state == ST_RAMP) || (r_state == ST_HOLD));
    assign w_accept  = cmd_valid && cmd_ready;
    assign freq      = PWM_FREQ[31:0];
    assign duty      = r_duty;
    assign dir       = r_dir;
    assign busy      = is_busy(r_state);
    assign state     = r_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_duty      <= '0;
            r_target    <= '0;
            r_dir       <= 1'b0;
            r_pend_dir  <= 1'b0;
            r_pend_duty <= '0;
            r_dead_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_duty      <= w_duty_nxt;
            r_target    <= w_target_nxt;
            r_dir       <= w_dir_nxt;
            r_pend_dir  <= w_pend_dir_nxt;
            r_pend_duty <= w_pend_duty_nxt;
            r_dead_cnt  <= w_dead_cnt_nxt;
        end
    end

    always_comb begin
        w_ramp_duty     = ramp_step(r_duty, r_target);
        w_state_nxt     = r_state;
        w_duty_nxt      = r_duty;
        w_target_nxt    = r_target;
        w_dir_nxt       = r_dir;
        w_pend_dir_nxt  = r_pend_dir;
        w_pend_duty_nxt = r_pend_duty;
        w_dead_cnt_nxt  = r_dead_cnt;

        if (estop) begin
            w_state_nxt    = ST_IDLE;
            w_duty_nxt     = '0;
            w_target_nxt   = '0;
            w_dead_cnt_nxt = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_duty_nxt = '0;
                end
                ST_HOLD: begin
                end
                ST_RAMP: begin
                    if (w_tick) begin
                        w_duty_nxt = w_ramp_duty;
                        if (w_ramp_duty == r_target) begin
                            w_state_nxt = (r_target != '0) ? ST_HOLD : ST_IDLE;
                        end
                    end
                end
                ST_BRAKE: begin
                    if (r_duty == '0) begin
                        w_state_nxt    = ST_DEAD;
                        w_dead_cnt_nxt = '0;
                    end else if (w_tick) begin
                        w_duty_nxt = w_ramp_duty;
                        if (w_ramp_duty == '0) begin
                            w_state_nxt    = ST_DEAD;
                            w_dead_cnt_nxt = '0;
                        end
                    end
                end
                ST_DEAD: begin
                    w_duty_nxt = '0;
                    if (w_tick) begin
                        if (r_dead_cnt == DEAD_LAST) begin
                            w_dir_nxt      = r_pend_dir;
                            w_target_nxt   = r_pend_duty;
                            w_dead_cnt_nxt = '0;
                            w_state_nxt    = (r_pend_duty != '0) ? ST_RAMP : ST_IDLE;
                        end else begin
                            w_dead_cnt_nxt = r_dead_cnt + DEAD_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_duty_nxt  = '0;
                end
            endcase

            // A same-cycle tick has already stepped with the old target above.
            if (w_accept) begin
                if (cmd_dir == r_dir) begin
                    w_target_nxt = cmd_duty;
                    if (cmd_duty != w_duty_nxt) begin
                        w_state_nxt = ST_RAMP;
                    end else begin
                        w_state_nxt = (cmd_duty != '0) ? ST_HOLD : ST_IDLE;
                    end
                end else begin
                    w_pend_dir_nxt  = cmd_dir;
                    w_pend_duty_nxt = cmd_duty;
                    w_target_nxt    = '0;
                    w_state_nxt     = ST_BRAKE;
                end
            end
        end
    end

endmodule
